// File: rtl/mux_select_sequencer.sv
// Parallel-to-serial front end for variable_mux: holds an M-bit word on mux_data
// and walks mux_sel across every index, one accepted bit per step.
module mux_select_sequencer #(
  parameter int N         = 3,
  parameter int M         = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [M-1:0] load_data,
  input  logic         out_ready,
  output logic [M-1:0] mux_data,
  output logic [N-1:0] mux_sel,
  output logic         bit_valid,
  output logic         bit_last,
  output logic         busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [N-1:0] FIRST = MSB_FIRST ? N'(M-1) : '0;
  localparam logic [N-1:0] LAST  = MSB_FIRST ? '0 : N'(M-1);

  logic [0:0]   state;
  logic [M-1:0] pend_data;
  logic         pend_full;

  logic load_fire, acc, at_last, wrap;

  assign load_ready = !pend_full;
  assign load_fire  = load_valid && load_ready;
  assign bit_valid  = (state == SHIFT);
  assign acc        = bit_valid && out_ready;
  assign at_last    = (mux_sel == LAST);
  assign wrap       = acc && at_last;
  assign bit_last   = bit_valid && at_last;
  assign busy       = (state == SHIFT) || pend_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mux_data  <= '0;
      mux_sel   <= FIRST;
      pend_data <= '0;
      pend_full <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_fire) begin
            mux_data <= load_data;
            mux_sel  <= FIRST;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (acc && !at_last) begin
            mux_sel <= MSB_FIRST ? mux_sel - N'(1) : mux_sel + N'(1);
          end else if (wrap) begin
            mux_sel <= FIRST;
            // Pending word outranks a same-cycle load; load_ready is low then anyway.
            if (pend_full) begin
              mux_data  <= pend_data;
              pend_full <= 1'b0;
            end else if (load_fire) begin
              mux_data <= load_data;
            end else begin
              state <= IDLE;
            end
          end
          // A load that was not taken straight into the active word waits here.
          if (load_fire && !(wrap && !pend_full)) begin
            pend_data <= load_data;
            pend_full <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
